shift_add_multiplier: RTL and testbench

Sequential radix-2 shift-add unsigned multiplier for the 64-bit MIPS datapath's multiply/divide unit. It is the forward counterpart of the divider: it takes two WIDTH-bit operands and produces a 2*WIDTH-bit product over a fixed number of cycles. A start pulse launches an operation, and a `rdy` flag signals completion. Results feed HI/LO, and the product can be checked by dividing it back through the divider.

---
 rtl/mips_arith_pkg.sv | 13 +
 rtl/shift_add_multiplier.sv | 82 ++++++++
 tb/tb_shift_add_multiplier.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_arith_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
// Holds the common operand width and the sequencer state encoding.
package mips_arith_pkg;

  localparam int ARITH_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arith_state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add unsigned multiplier, WIDTH cycles per product.
// Ports: clk, rst (sync, active-high), start, a, b -> product, rdy.
module shift_add_multiplier
  import mips_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               rdy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  arith_state_e       state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               rdy_q;

  // Partial-product add for the current iteration; the 2*WIDTH-bit
  // accumulator can never overflow for WIDTH-bit operands.
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (mplr_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q <= {{WIDTH{1'b0}}, a};
            mplr_q  <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          // Last iteration: publish the sum including this cycle's add.
          if (cnt_q == LAST) begin
            product_q <= acc_d;
            rdy_q     <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign product = product_q;
  assign rdy     = rdy_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Directed vector table, hand sequences, and random cross-check.
module tb_shift_add_multiplier;

  localparam int W = 64;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           rdy;

  int checks;
  int failures;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .rdy     (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] vp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm,
                     input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(input int inj, output int cyc);
    cyc = 0;
    while (!rdy && cyc < 200) begin
      if (cyc == inj) begin
        start = 1'b1;
        a = 64'd3;
        b = 64'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic accept(input logic [W-1:0] av,
                        input logic [W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '1;
    b = '1;
    chk("accept_rdy_low", {127'd0, rdy}, 128'd0);
  endtask

  task automatic run_op(input string nm,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp,
                        input int inj);
    int cyc;
    accept(av, bv);
    wait_rdy(inj, cyc);
    chk({nm, "_latency"}, 128'(cyc), 128'd64);
    chk({nm, "_product"}, product, exp);
  endtask

  initial begin
    int ok;
    int cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2*W-1:0] rp;

    checks   = 0;
    failures = 0;

    vecs[0] = '{64'd500, 64'd25, 128'd12500};
    vecs[1] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[3] = '{64'd1, 64'd1, 128'd1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd2,
                128'h1_0000_0000_0000_0000};
    vecs[5] = '{64'h1234_5678, 64'h10, 128'h1_2345_6780};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                128'hFFFF_FFFF_FFFF_FFFF};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {127'd0, rdy}, 128'd0);
    chk("reset_product", product, 128'd0);
    rst = 1'b0;

    // Basic op, then result must hold in DONE.
    run_op("basic", 64'd500, 64'd25, 128'd12500, -1);
    ok = 1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rdy !== 1'b1 || product !== 128'd12500) ok = 0;
    end
    chk("basic_hold", 128'(ok), 128'd1);

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
             vecs[i].vp, -1);
    end

    // Start pulse during BUSY is ignored.
    run_op("busy_start", 64'd7, 64'd9, 128'd63, 10);
    ok = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rdy !== 1'b1 || product !== 128'd63) ok = 0;
    end
    chk("busy_start_hold", 128'(ok), 128'd1);

    // Reset in the middle of BUSY aborts the operation.
    accept(64'd11, 64'd13);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_rdy", {127'd0, rdy}, 128'd0);
    chk("midrst_product", product, 128'd0);
    ok = 1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (rdy !== 1'b0) ok = 0;
    end
    chk("midrst_no_rdy", 128'(ok), 128'd1);
    run_op("after_rst", 64'd6, 64'd7, 128'd42, -1);

    // Reset and start together: reset wins, nothing launches.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 64'd5;
    b     = 64'd5;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    ok = 1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (rdy !== 1'b0 || product !== 128'd0) ok = 0;
    end
    chk("rst_start_idle", 128'(ok), 128'd1);

    // Back-to-back from DONE with no IDLE cycle.
    run_op("pre_b2b", 64'd1, 64'd1, 128'd1, -1);
    accept(64'h8000_0000_0000_0000, 64'd2);
    chk("b2b_old_product", product, 128'd1);
    wait_rdy(-1, cyc);
    chk("b2b_latency", 128'(cyc), 128'd64);
    chk("b2b_product", product, 128'h1_0000_0000_0000_0000);

    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 7 == 0) rb = rb >> ($urandom_range(0, 63));
      rp = {64'd0, ra} * {64'd0, rb};
      run_op("rand", ra, rb, rp, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
